dram_copy_engine: RTL and testbench

Initiator-side master for the 8-bit synchronous DRAM used by the matrix multiplier. It copies a block of `length` bytes from `src_addr` to `dst_addr`, byte by byte in ascending order. It drives the DRAM address/data/rden/wren inputs and consumes its registered `q` output, which has 1-cycle read latency. The top-level sequencer uses it to stage matrix operands and move results.

---
 rtl/dram_copy_engine.sv | 123 ++++++++++++
 tb/tb_dram_copy_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_copy_engine.sv
// Forward byte-copy master for the 8-bit synchronous DRAM: READ src+i, then WRITE dst+i with q.
// Optional running byte checksum output is enabled by defining DRAM_COPY_CHECKSUM_EN.
module dram_copy_engine #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
`ifdef DRAM_COPY_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [1:0]            dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  idx_q, idx_d;
  logic [LEN_WIDTH-1:0]  idx_inc;

  // Index never exceeds length-1, so idx+1 always fits in LEN_WIDTH bits.
  assign idx_inc = idx_q + LEN_WIDTH'(1);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    idx_d       = idx_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_rden    = 1'b0;
    mem_wren    = 1'b0;
    mem_address = '0;
    mem_data    = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          idx_d   = '0;
          state_d = (length != '0) ? READ : DONE;
        end
      end
      READ: begin
        busy        = 1'b1;
        mem_rden    = 1'b1;
        mem_address = src_q + ADDR_WIDTH'(idx_q);
        state_d     = WRITE;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_wren    = 1'b1;
        mem_address = dst_q + ADDR_WIDTH'(idx_q);
        mem_data    = mem_q;
        idx_d       = idx_inc;
        state_d     = (idx_inc == len_q) ? DONE : READ;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dbg_state = state_q;

`ifdef DRAM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (state_q == IDLE && start) csum_d = '0;
    else if (state_q == WRITE)    csum_d = csum_q + mem_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) csum_q <= '0;
    else         csum_q <= csum_d;
  end

  assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_dram_copy_engine.sv
// Directed bench for dram_copy_engine: expected DRAM strobes/done go into a queue, a negedge monitor pops and compares.
// Checksum checks are compiled in when DRAM_COPY_CHECKSUM_EN is defined.
module tb_dram_copy_engine;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int LW = 10;

  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;
  localparam logic [1:0] K_DN = 2'd3;

  logic          clock;
  logic          resetn;
  logic          start;
  logic [AW-1:0] src_addr, dst_addr;
  logic [LW-1:0] length;
  logic          busy, done, mem_rden, mem_wren;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic [1:0]    dbg_state;
`ifdef DRAM_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum;
`endif

  int errors = 0;
  int checks = 0;

  // Expected events: {kind, address, data}
  logic [2+AW+DW-1:0] exp_q[$];
  logic [DW-1:0]      exp_data [0:7];
  logic [DW-1:0]      dram [0:65535];

  dram_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock(clock), .resetn(resetn), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
    .busy(busy), .done(done), .mem_address(mem_address), .mem_data(mem_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_q(mem_q),
`ifdef DRAM_COPY_CHECKSUM_EN
    .checksum(checksum),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // DRAM model: registered q, one-cycle read latency
  always @(posedge clock) begin
    if (mem_wren) dram[mem_address] <= mem_data;
    if (mem_rden) mem_q <= dram[mem_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    logic [2+AW+DW-1:0] e;
    if (resetn) begin
      check("rden_wren_exclusive", {31'd0, mem_rden & mem_wren}, 32'd0);
      if (mem_rden || mem_wren || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event", {29'd0, mem_rden, mem_wren, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", {30'd0, mem_wren | done, mem_rden | done}, {30'd0, e[2+AW+DW-1 -: 2]});
          if (!done) check("event_addr", {16'd0, mem_address}, {16'd0, e[AW+DW-1 -: AW]});
          if (mem_wren) check("write_data", {24'd0, mem_data}, {24'd0, e[DW-1:0]});
        end
      end else begin
        check("idle_addr_data_zero", {8'd0, mem_address, mem_data}, 32'd0);
      end
    end
  end

  task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input int len, input bit inject);
    int busy_cnt, gap_cnt;
    bit got_done;
    logic [DW-1:0] sum;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back({K_RD, AW'(s + AW'(i)), 8'h00});
      exp_q.push_back({K_WR, AW'(d + AW'(i)), exp_data[i]});
      sum = sum + exp_data[i];
    end
    exp_q.push_back({K_DN, 16'h0000, 8'h00});
    @(negedge clock);
    src_addr = s; dst_addr = d; length = LW'(len); start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    busy_cnt = 0; gap_cnt = 0; got_done = 0;
    for (int k = 0; k < 2 * len + 10; k++) begin
      @(negedge clock);
      if (inject && k == 1) begin
        start = 1'b1; src_addr = 16'h0F00; dst_addr = 16'h0F80; length = 10'd7;
      end
      if (inject && k == 2) start = 1'b0;
      if (done) begin
        got_done = 1;
`ifdef DRAM_COPY_CHECKSUM_EN
        check("checksum", {24'd0, checksum}, {24'd0, sum});
`endif
        check("busy_low_in_done", {31'd0, busy}, 32'd0);
        break;
      end
      if (busy) busy_cnt++;
      else gap_cnt++;
    end
    check("done_seen", {31'd0, got_done}, 32'd1);
    check("busy_cycles", busy_cnt, 2 * len);
    check("cycles_before_busy_or_gap", gap_cnt, 0);
    @(negedge clock);
    check("done_single_pulse", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    for (int a = 0; a < 65536; a++) dram[a] = 8'h00;
    #12;
    check("reset_outputs", {8'd0, busy, done, mem_rden, mem_wren, mem_address, 4'd0},
          32'd0);
    check("reset_data", {24'd0, mem_data}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clock); resetn = 1'b1;

    // 1: plain 4-byte copy
    dram[0] = 8'h11; dram[1] = 8'h22; dram[2] = 8'h33; dram[3] = 8'h44;
    exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33; exp_data[3] = 8'h44;
    run_copy(16'h0000, 16'h0100, 4, 0);
    check("t1_dst0", {24'd0, dram[16'h0100]}, 32'h11);
    check("t1_dst3", {24'd0, dram[16'h0103]}, 32'h44);

    // 2: zero length
    run_copy(16'h0000, 16'h0200, 0, 0);

    // 3: forward overlap replicates leading byte
    dram[0] = 8'h5A; dram[1] = 8'h00; dram[2] = 8'h00; dram[3] = 8'h00;
    exp_data[0] = 8'h5A; exp_data[1] = 8'h5A; exp_data[2] = 8'h5A;
    run_copy(16'h0000, 16'h0001, 3, 0);
    check("t3_dram3", {24'd0, dram[3]}, 32'h5A);

    // 4: source address wraps
    dram[16'hFFFE] = 8'hA1; dram[16'hFFFF] = 8'hB2; dram[16'h0000] = 8'hC3;
    exp_data[0] = 8'hA1; exp_data[1] = 8'hB2; exp_data[2] = 8'hC3;
    run_copy(16'hFFFE, 16'h0010, 3, 0);
    check("t4_dst2", {24'd0, dram[16'h0012]}, 32'hC3);

    // 5: start during copy is ignored
    dram[16'h0200] = 8'h01; dram[16'h0201] = 8'h02; dram[16'h0202] = 8'h03; dram[16'h0203] = 8'h04;
    exp_data[0] = 8'h01; exp_data[1] = 8'h02; exp_data[2] = 8'h03; exp_data[3] = 8'h04;
    run_copy(16'h0200, 16'h0300, 4, 1);
    check("t5_dst3", {24'd0, dram[16'h0303]}, 32'h04);
    check("t5_no_stray_write", {24'd0, dram[16'h0F80]}, 32'h00);

    // 6: reset during the third WRITE
    for (int i = 0; i < 8; i++) begin
      dram[16'h0400 + i] = 8'h10 + 8'(i);
      dram[16'h0500 + i] = 8'hEE;
    end
    exp_q.push_back({K_RD, 16'h0400, 8'h00});
    exp_q.push_back({K_WR, 16'h0500, 8'h10});
    exp_q.push_back({K_RD, 16'h0401, 8'h00});
    exp_q.push_back({K_WR, 16'h0501, 8'h11});
    exp_q.push_back({K_RD, 16'h0402, 8'h00});
    @(negedge clock);
    src_addr = 16'h0400; dst_addr = 16'h0500; length = 10'd8; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (5) @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("t6_async_reset_outputs", {8'd0, busy, done, mem_rden, mem_wren, mem_address, 4'd0},
          32'd0);
    check("t6_async_reset_data", {24'd0, mem_data}, 32'd0);
    repeat (2) @(negedge clock);
    check("t6_queue_drained", exp_q.size(), 0);
    check("t6_dst0", {24'd0, dram[16'h0500]}, 32'h10);
    check("t6_dst1", {24'd0, dram[16'h0501]}, 32'h11);
    check("t6_dst2_untouched", {24'd0, dram[16'h0502]}, 32'hEE);
    resetn = 1'b1;
    exp_data[0] = 8'h10; exp_data[1] = 8'h11;
    run_copy(16'h0400, 16'h0600, 2, 0);
    check("t6_fresh_dst1", {24'd0, dram[16'h0601]}, 32'h11);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
